// File: rtl/apb_slv_pkg.sv
// apb_slv_pkg: shared types and constants for the APB register completer.
//   state_t       - transfer FSM states (IDLE, WAIT, DONE)
//   REG_*         - byte offsets of the register map
//   DEFAULT_ID    - default contents of the read-only ID register
//   dec_t         - decode result latched at the setup edge
//   strb_mask()   - expands byte strobes into a 32-bit bit mask
//   strb_merge()  - byte-lane merge of write data into an old value
package apb_slv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    localparam logic [7:0] REG_ID       = 8'h00;
    localparam logic [7:0] REG_STATUS   = 8'h04;
    localparam logic [7:0] REG_IRQ_PEND = 8'h08;
    localparam logic [7:0] REG_IRQ_MASK = 8'h0C;
    localparam logic [7:0] REG_SCRATCH0 = 8'h10;

    localparam logic [31:0] DEFAULT_ID = 32'hAB1E_0001;

    typedef struct packed {
        logic        err;    // access is out of map, misaligned or writes a RO register
        logic [31:0] rdata;  // read value, already forced to 0 for bad/write accesses
    } dec_t;

    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

    function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  strb);
        logic [31:0] m;
        m = strb_mask(strb);
        return (old_val & ~m) | (wdata & m);
    endfunction

endpackage

// File: rtl/apb_slv_fsm.sv
// apb_slv_fsm: APB transfer sequencer (IDLE -> WAIT -> DONE -> IDLE).
//   clk, rst      - clock, asynchronous active-high reset
//   psel, penable - APB handshake inputs
//   pwrite        - write qualifier for the commit strobe
//   setup         - setup phase accepted this cycle (latch decode at this edge)
//   commit        - write commits at this edge (last edge of DONE)
//   pready        - registered completion, high only in DONE
// Dropping psel in any state returns to IDLE without a commit.
module apb_slv_fsm
    import apb_slv_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic psel,
    input  logic penable,
    input  logic pwrite,
    output logic setup,
    output logic commit,
    output logic pready
);

    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t     state;
    logic [3:0] cnt;

    assign setup  = (state == IDLE) && psel && !penable;
    assign commit = (state == DONE) && psel && penable && pwrite;

    // pready is registered alongside the state so it never depends on
    // the APB inputs combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            pready <= 1'b0;
        end else if (!psel) begin
            state  <= IDLE;
            pready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!penable) begin
                        if (WAIT_CYCLES == 0) begin
                            state  <= DONE;
                            pready <= 1'b1;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state  <= DONE;
                        pready <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    pready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/apb_reg_slave.sv
// apb_reg_slave: APB3/APB4 completer with a small register bank.
//   Map: 0x00 ID (RO), 0x04 STATUS (RO, status_i delayed one cycle),
//        0x08 IRQ_PEND (W1C, set by event_i), 0x0C IRQ_MASK (RW),
//        0x10.. SCRATCH (RW). NUM_REGS must be at least 5.
//   Ports: clk, rst (async active-high); APB psel/penable/pwrite/paddr/
//          pwdata/pstrb/pprot (pprot ignored) -> prdata/pready/pslverr;
//          status_i, event_i sideband in; irq_o registered interrupt out.
//   Config macro APB_SLV_ERR_EN: when defined, bad accesses (out of map,
//          misaligned, write to ID/STATUS) report pslverr; otherwise pslverr
//          is tied 0. Either way bad writes are dropped and bad reads give 0.
module apb_reg_slave
    import apb_slv_pkg::*;
#(
    parameter int          addrWidth   = 32,
    parameter int          dataWidth   = 32,
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] ID_VALUE    = DEFAULT_ID
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   psel,
    input  logic                   penable,
    input  logic                   pwrite,
    input  logic [addrWidth-1:0]   paddr,
    input  logic [dataWidth-1:0]   pwdata,
    input  logic [dataWidth/8-1:0] pstrb,
    input  logic [2:0]             pprot,
    output logic [dataWidth-1:0]   prdata,
    output logic                   pready,
    output logic                   pslverr,
    input  logic [dataWidth-1:0]   status_i,
    input  logic [dataWidth-1:0]   event_i,
    output logic                   irq_o
);

    localparam int IDX_W   = $clog2(NUM_REGS);
    localparam int NUM_SCR = NUM_REGS - 4;

    localparam logic [IDX_W-1:0] I_ID     = IDX_W'(REG_ID >> 2);
    localparam logic [IDX_W-1:0] I_STATUS = IDX_W'(REG_STATUS >> 2);
    localparam logic [IDX_W-1:0] I_PEND   = IDX_W'(REG_IRQ_PEND >> 2);
    localparam logic [IDX_W-1:0] I_MASK   = IDX_W'(REG_IRQ_MASK >> 2);
    localparam int               SCR0     = int'(REG_SCRATCH0 >> 2);

    logic                 setup;
    logic                 commit;
    logic                 wr_en;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     idx_q;
    logic                 bad;
    logic [dataWidth-1:0] rd_val;
    logic [dataWidth-1:0] pend_clr;
    dec_t                 dec_q;

    logic [dataWidth-1:0] status_q;
    logic [dataWidth-1:0] pend_q;
    logic [dataWidth-1:0] mask_q;
    logic [dataWidth-1:0] scratch [NUM_SCR];

    logic unused_ok;
    assign unused_ok = ^pprot;

    apb_slv_fsm #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_fsm (
        .clk    (clk),
        .rst    (rst),
        .psel   (psel),
        .penable(penable),
        .pwrite (pwrite),
        .setup  (setup),
        .commit (commit),
        .pready (pready)
    );

    // ---------------- decode (sampled at the setup edge) ----------------
    assign idx = paddr[2 +: IDX_W];
    assign bad = (paddr >= addrWidth'(NUM_REGS * 4)) ||
                 (paddr[1:0] != 2'b00) ||
                 (pwrite && ((idx == I_ID) || (idx == I_STATUS)));

    always_comb begin
        rd_val = '0;
        case (idx)
            I_ID:     rd_val = ID_VALUE;
            I_STATUS: rd_val = status_q;
            I_PEND:   rd_val = pend_q;
            I_MASK:   rd_val = mask_q;
            default: begin
                for (int r = 0; r < NUM_SCR; r++) begin
                    if (idx == IDX_W'(r + SCR0)) rd_val = scratch[r];
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
            dec_q <= '0;
        end else if (setup) begin
            idx_q       <= idx;
            dec_q.err   <= bad;
            dec_q.rdata <= (bad || pwrite) ? '0 : rd_val;
        end
    end

    // ---------------- register bank ----------------
    assign wr_en    = commit && !dec_q.err;
    assign pend_clr = (wr_en && idx_q == I_PEND) ? (pwdata & strb_mask(pstrb)) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q <= '0;
            pend_q   <= '0;
            mask_q   <= '0;
            irq_o    <= 1'b0;
            for (int r = 0; r < NUM_SCR; r++) scratch[r] <= '0;
        end else begin
            status_q <= status_i;
            // event_i is OR-ed after the clear so a same-cycle event wins
            pend_q   <= (pend_q & ~pend_clr) | event_i;
            irq_o    <= |(pend_q & mask_q);
            if (wr_en && idx_q == I_MASK) mask_q <= strb_merge(mask_q, pwdata, pstrb);
            for (int r = 0; r < NUM_SCR; r++) begin
                if (wr_en && idx_q == IDX_W'(r + SCR0))
                    scratch[r] <= strb_merge(scratch[r], pwdata, pstrb);
            end
        end
    end

    // ---------------- response ----------------
    assign prdata = pready ? dec_q.rdata : '0;
`ifdef APB_SLV_ERR_EN
    assign pslverr = pready && dec_q.err;
`else
    assign pslverr = 1'b0;
`endif

endmodule

// File: tb/tb_apb_reg_slave.sv
module tb_apb_reg_slave;

    localparam int WAIT_CYCLES = 2;
    localparam int ACC_LAT     = WAIT_CYCLES + 1;
`ifdef APB_SLV_ERR_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [31:0] status_i, event_i;
    logic        irq_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        err;
        bit          chk_data;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    apb_reg_slave #(
        .addrWidth(32), .dataWidth(32), .NUM_REGS(8),
        .WAIT_CYCLES(WAIT_CYCLES), .ID_VALUE(32'hAB1E_0001)
    ) dut (
        .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .status_i(status_i), .event_i(event_i), .irq_o(irq_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full APB transfer; event_i is held at ev for its whole duration.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [31:0] ev);
        exp_t e;
        int   lat;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
        pwdata = wdata; pstrb = strb; event_i = ev;
        @(posedge clk); #1;
        penable = 1'b1;
        lat = 1;
        @(negedge clk);
        while (!pready && lat < 20) begin
            lat++;
            @(negedge clk);
        end
        e = sb.pop_front();
        chk({e.tag, ".lat"}, 32'(lat), 32'(ACC_LAT));
        chk({e.tag, ".err"}, {31'd0, pslverr}, {31'd0, e.err});
        if (e.chk_data) chk({e.tag, ".data"}, prdata, e.data);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; event_i = '0;
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr,
                           input logic [31:0] exp_data, input logic exp_err);
        sb.push_back('{tag, exp_data, exp_err, 1'b1});
        xfer(1'b0, addr, '0, 4'h0, '0);
    endtask

    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [31:0] ev, input logic exp_err);
        sb.push_back('{tag, '0, exp_err, 1'b0});
        xfer(1'b1, addr, data, strb, ev);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic stuck;
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
        pwdata = '0; pstrb = '0; pprot = '0; status_i = '0; event_i = '0;
        repeat (3) @(negedge clk);
        chk("rst.prdata", prdata, '0);
        chk("rst.pready", {31'd0, pready}, '0);
        chk("rst.pslverr", {31'd0, pslverr}, '0);
        chk("rst.irq", {31'd0, irq_o}, '0);
        @(posedge clk); #1 rst = 1'b0;

        do_read("id", 32'h00, 32'hAB1E_0001, 1'b0);
        do_write("wr_scr0", 32'h10, 32'hDEAD_BEEF, 4'hF, '0, 1'b0);
        do_read("rd_scr0", 32'h10, 32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        chk("idle.prdata", prdata, '0);
        do_write("wr_scr1", 32'h14, 32'h1122_3344, 4'b0101, '0, 1'b0);
        do_read("rd_scr1", 32'h14, 32'h0022_0044, 1'b0);

        // bad accesses
        do_write("wr_id", 32'h00, 32'hFFFF_FFFF, 4'hF, '0, ERR);
        do_read("id_kept", 32'h00, 32'hAB1E_0001, 1'b0);
        do_write("wr_status", 32'h04, 32'h1234_5678, 4'hF, '0, ERR);
        do_read("rd_oor", 32'h40, 32'h0, ERR);
        do_read("rd_misal", 32'h11, 32'h0, ERR);
        do_write("wr_oor", 32'h40, 32'hFFFF_FFFF, 4'hF, '0, ERR);
        do_read("scr0_kept", 32'h10, 32'hDEAD_BEEF, 1'b0);

        status_i = 32'hCAFE_F00D;
        do_read("status", 32'h04, 32'hCAFE_F00D, 1'b0);

        // interrupts
        do_write("wr_mask", 32'h0C, 32'h4, 4'hF, '0, 1'b0);
        @(posedge clk); #1 event_i = 32'h5;
        @(posedge clk); #1 event_i = '0;
        @(negedge clk);
        chk("irq.lag", {31'd0, irq_o}, '0);
        @(negedge clk);
        chk("irq.set", {31'd0, irq_o}, 32'd1);
        do_read("pend5", 32'h08, 32'h5, 1'b0);
        do_write("w1c_ev", 32'h08, 32'h4, 4'hF, 32'h4, 1'b0);
        do_read("pend_setwins", 32'h08, 32'h5, 1'b0);
        do_write("w1c", 32'h08, 32'h4, 4'hF, '0, 1'b0);
        repeat (2) @(negedge clk);
        chk("irq.clr", {31'd0, irq_o}, '0);
        do_read("pend1", 32'h08, 32'h1, 1'b0);
        do_write("w1c_strb", 32'h08, 32'hFFFF_FFFF, 4'b1110, '0, 1'b0);
        do_read("pend_strb", 32'h08, 32'h1, 1'b0);

        // psel dropped during WAIT
        do_write("wr_scr2", 32'h18, 32'hA5A5_5A5A, 4'hF, '0, 1'b0);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h18;
        pwdata = 32'hFFFF_0000; pstrb = 4'hF;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
        stuck = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (pready) stuck = 1'b1;
        end
        chk("abort.pready", {31'd0, stuck}, '0);
        do_read("abort.kept", 32'h18, 32'hA5A5_5A5A, 1'b0);

        // reset during WAIT of a write
        do_write("wr_mask5", 32'h0C, 32'h5, 4'hF, '0, 1'b0);
        repeat (2) @(negedge clk);
        chk("irq.pre_rst", {31'd0, irq_o}, 32'd1);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h1C;
        pwdata = 32'h0000_0099; pstrb = 4'hF;
        @(posedge clk); #1 penable = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst.prdata", prdata, '0);
        chk("mid_rst.pready", {31'd0, pready}, '0);
        chk("mid_rst.pslverr", {31'd0, pslverr}, '0);
        chk("mid_rst.irq", {31'd0, irq_o}, '0);
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        do_read("rst.scr3", 32'h1C, 32'h0, 1'b0);
        do_read("rst.id", 32'h00, 32'hAB1E_0001, 1'b0);
        do_read("rst.scr0", 32'h10, 32'h0, 1'b0);
        do_read("rst.mask", 32'h0C, 32'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
